mem_initiator: RTL and testbench
================================

// Module: mem_initiator
// PURPOSE
//  Bus-side initiator for the 4-bank x 1024 x 8 memory model. Accepts single-beat read/write/clear
//  requests over a valid/ready handshake and drives cen/rd/wr/add/din/rst pins with the model's timing.
//  Captures dout after a fixed read latency and returns a one-cycle response pulse.
//  Sits between the test sequencer and the memory model; exactly one request in flight at a time.
// PARAMETERS
//  RD_LAT   2     clocks from the rd-asserted cycle to the capture edge of mem_dout (range 1..15)
//  WR_HOLD  2     clocks mem_add/mem_din are held stable after the wr-asserted cycle (range 1..15)
//  CLR_CYC  4     clocks mem_rst stays high for a clear operation (range 1..15)
// PORTS
//  clk        in   1   system clock, all logic on posedge
//  rst        in   1   synchronous active-high reset
//  req_valid  in   1   request present
//  req_ready  out  1   block can accept; transfer when req_valid && req_ready on a posedge
//  req_op     in   2   00 read, 01 write, 10 clear, 11 illegal
//  req_addr   in   12  [11:10] bank, [9:0] word
//  req_wdata  in   8   write data
//  rsp_valid  out  1   one-cycle completion pulse (no backpressure)
//  rsp_rdata  out  8   read data; 8'h00 for write/clear/illegal
//  rsp_err    out  1   high with rsp_valid for op 11 or when mem_dout had X/Z bits at capture
//  mem_cen    out  1   chip enable to memory, active-low
//  mem_rst    out  1   memory clear strobe, active-high
//  mem_rd     out  1   read strobe
//  mem_wr     out  1   write strobe
//  mem_add    out  12  memory address
//  mem_din    out  8   memory write data
//  mem_dout   in   8   memory read data
// BEHAVIOUR
//  Reset (rst high at posedge, any state): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//   mem_cen=1, mem_rst=0, mem_rd=0, mem_wr=0, mem_add=0, mem_din=0, counter=0. In-flight op dropped, no rsp.
//  req_ready=1 only in IDLE. Accept latches op/addr/wdata into registers; later req_* changes ignored.
//  States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_HOLD, CLR, RESP.
//  IDLE: accept -> op00 RD_ISSUE, op01 WR_ISSUE, op10 CLR, op11 RESP (err=1); outputs cen=1.
//  RD_ISSUE (1 clk): cen=0, rd=1, add=addr; cnt=RD_LAT-1; -> RD_WAIT (rd drops, cen/add held).
//  RD_WAIT: cen=0; decrement cnt; at cnt==0 capture mem_dout into rsp_rdata -> RESP.
//   Read accept-to-rsp_valid latency = RD_LAT+2 clocks.
//  WR_ISSUE (1 clk): cen=0, wr=1, add=addr, din=wdata; cnt=WR_HOLD-1 -> WR_HOLD.
//  WR_HOLD: wr=0, cen=0, add/din held; at cnt==0 -> RESP. Latency WR_HOLD+2.
//  CLR: cen=0, mem_rst=1 for CLR_CYC clocks, rd=wr=0 -> RESP. Latency CLR_CYC+1.
//  RESP (1 clk): rsp_valid=1 with rsp_rdata/rsp_err; cen=1, rd=wr=rst=0; -> IDLE.
//   rsp_rdata/rsp_err hold until next RESP; rsp_valid low elsewhere.
//  Min one cen-high clock (RESP+IDLE) between consecutive ops; back-to-back accept earliest in IDLE after RESP.
//  mem_rd and mem_wr never high in the same cycle; mem_rst never high with rd or wr.
//  Counters 4 bits, decrement only, no wrap; parameter 0 is illegal (elaboration $error).
//  X-check: rsp_err=1 on a read if ^mem_dout is X at capture; rsp_rdata still takes captured value.
//  Bank field passed through unmodified; no address range error (all 4096 addresses valid).
// TESTING
//  rst 2 clks -> all outputs at reset values, req_ready=1, mem_cen=1.
//  write 0xA5 @0x3FF then read 0x3FF -> mem_wr pulse 1 clk, rsp_valid at +4; read rsp_rdata=0xA5 at +4, err=0.
//  write 0x5A @0xC00 (bank3), read 0x000 -> bank0 unaffected, read returns 0x00 after clear/reset memory.
//  clear op -> mem_rst high exactly 4 clks, cen=0; subsequent read of 0x3FF returns 0x00.
//  op 11 -> no mem_rd/mem_wr/mem_rst, rsp_valid next+1 clk with rsp_err=1, rsp_rdata=0.
//  rst asserted during RD_WAIT -> no rsp_valid, mem_cen=1 next clk, req_ready=1; new read completes normally.

Source files
------------

// File: rtl/mem_initiator.sv
// ============================================================================
// Module  : mem_initiator
// Purpose : Single-outstanding valid/ready initiator driving the banked
//           memory model pins (cen/rd/wr/rst/add/din) and returning responses.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_initiator #(
  parameter int RD_LAT  = 2,
  parameter int WR_HOLD = 2,
  parameter int CLR_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        mem_cen,
  output logic        mem_rst,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [11:0] mem_add,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout
);

  if (RD_LAT < 1 || RD_LAT > 15) begin : g_rd_lat_chk
    $error("mem_initiator: RD_LAT must be in 1..15");
  end
  if (WR_HOLD < 1 || WR_HOLD > 15) begin : g_wr_hold_chk
    $error("mem_initiator: WR_HOLD must be in 1..15");
  end
  if (CLR_CYC < 1 || CLR_CYC > 15) begin : g_clr_cyc_chk
    $error("mem_initiator: CLR_CYC must be in 1..15");
  end

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  localparam logic [3:0] RD_CNT  = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_CNT  = 4'(WR_HOLD - 1);
  localparam logic [3:0] CLR_CNT = 4'(CLR_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_WR_ISSUE = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_CLR      = 3'd5,
    S_RESP     = 3'd6
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [11:0] addr_q;
  logic [7:0]  din_q;
  logic [7:0]  rdata_q;
  logic        err_q;
  logic        accept;

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_cen   = 1'b1;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_rst   = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          case (req_op)
            OP_READ:  state_nxt = S_RD_ISSUE;
            OP_WRITE: state_nxt = S_WR_ISSUE;
            OP_CLEAR: state_nxt = S_CLR;
            default:  state_nxt = S_RESP;
          endcase
        end
      end
      S_RD_ISSUE: begin
        mem_cen   = 1'b0;
        mem_rd    = 1'b1;
        state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        mem_cen = 1'b0;
        if (cnt == 4'd0) state_nxt = S_RESP;
      end
      S_WR_ISSUE: begin
        mem_cen   = 1'b0;
        mem_wr    = 1'b1;
        state_nxt = S_WR_HOLD;
      end
      S_WR_HOLD: begin
        mem_cen = 1'b0;
        if (cnt == 4'd0) state_nxt = S_RESP;
      end
      S_CLR: begin
        mem_cen = 1'b0;
        mem_rst = 1'b1;
        if (cnt == 4'd0) state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Response fields only change on the edge that enters RESP, so they hold between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 4'd0;
      addr_q  <= 12'd0;
      din_q   <= 8'd0;
      rdata_q <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q <= req_addr;
            if (req_op == OP_WRITE) din_q <= req_wdata;
            if (req_op == OP_CLEAR) cnt <= CLR_CNT;
            if (req_op == 2'b11) begin
              rdata_q <= 8'd0;
              err_q   <= 1'b1;
            end
          end
        end
        S_RD_ISSUE: cnt <= RD_CNT;
        S_WR_ISSUE: cnt <= WR_CNT;
        S_RD_WAIT: begin
          if (cnt == 4'd0) begin
            rdata_q <= mem_dout;
            err_q   <= $isunknown(^mem_dout);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_WR_HOLD, S_CLR: begin
          if (cnt == 4'd0) begin
            rdata_q <= 8'd0;
            err_q   <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_add   = addr_q;
  assign mem_din   = din_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_initiator.sv
// ============================================================================
// Module  : tb_mem_initiator
// Purpose : Directed self-checking bench for mem_initiator with a memory model.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [11:0] req_addr = 12'd0;
  logic [7:0]  req_wdata = 8'd0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        mem_cen;
  logic        mem_rst;
  logic        mem_rd;
  logic        mem_wr;
  logic [11:0] mem_add;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout = 8'd0;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mem_initiator #(.RD_LAT(2), .WR_HOLD(2), .CLR_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_cen(mem_cen), .mem_rst(mem_rst), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_add(mem_add), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Memory model: registered read, synchronous write, whole-array clear on mem_rst.
  logic [7:0] mem [4096];
  logic model_clr = 1'b1;
  always @(posedge clk) begin
    if (model_clr || mem_rst) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'd0;
    end else if (!mem_cen && mem_wr) begin
      mem[mem_add] <= mem_din;
    end
    if (!mem_cen && mem_rd) mem_dout <= mem[mem_add];
  end

  // Drives one request and observes the pins until rsp_valid (bounded); returns on the RESP negedge.
  task automatic run_op(input logic [1:0] op, input logic [11:0] addr, input logic [7:0] wd,
                        output int lat, output logic [7:0] rdata, output logic err,
                        output int nrd, output int nwr, output int nrst, output int ncen,
                        output bit bad);
    lat = -1; rdata = 8'hxx; err = 1'bx;
    nrd = 0; nwr = 0; nrst = 0; ncen = 0; bad = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = 2'b01; req_addr = ~addr; req_wdata = ~wd;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k; rdata = rsp_rdata; err = rsp_err;
        break;
      end
      if (mem_rd) nrd++;
      if (mem_wr) nwr++;
      if (mem_rst) nrst++;
      if (!mem_cen) ncen++;
      if ((mem_rd && mem_wr) || (mem_rst && (mem_rd || mem_wr))) bad = 1;
      if (!mem_cen && mem_add !== addr) bad = 1;
      if (!mem_cen && op == 2'b01 && mem_din !== wd) bad = 1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_clr = 1'b0;
    nvec++; if (req_ready !== 1'b1) begin nfail++; $display("FAIL reset_ready got %b want 1", req_ready); end
    nvec++; if (mem_cen !== 1'b1) begin nfail++; $display("FAIL reset_cen got %b want 1", mem_cen); end
    nvec++; if ({rsp_valid, rsp_err, mem_rst, mem_rd, mem_wr} !== 5'b0) begin
      nfail++; $display("FAIL reset_strobes got %b want 00000", {rsp_valid, rsp_err, mem_rst, mem_rd, mem_wr}); end
    nvec++; if ({rsp_rdata, mem_add, mem_din} !== 28'h0) begin
      nfail++; $display("FAIL reset_data got %h want 0", {rsp_rdata, mem_add, mem_din}); end
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    int lat, nrd, nwr, nrst, ncen; logic [7:0] rd; logic er; bit bad;
    run_op(2'b01, 12'h3FF, 8'hA5, lat, rd, er, nrd, nwr, nrst, ncen, bad);
    nvec++; if (lat !== 4) begin nfail++; $display("FAIL wr_latency got %0d want 4", lat); end
    nvec++; if (nwr !== 1 || nrd !== 0 || nrst !== 0) begin
      nfail++; $display("FAIL wr_strobes got wr=%0d rd=%0d rst=%0d want 1/0/0", nwr, nrd, nrst); end
    nvec++; if (ncen !== 3) begin nfail++; $display("FAIL wr_cen_low got %0d want 3", ncen); end
    nvec++; if (bad !== 1'b0) begin nfail++; $display("FAIL wr_pins got bad=%0d want 0", bad); end
    nvec++; if (rd !== 8'h00 || er !== 1'b0) begin nfail++; $display("FAIL wr_rsp got %h/%b want 00/0", rd, er); end
    run_op(2'b00, 12'h3FF, 8'h00, lat, rd, er, nrd, nwr, nrst, ncen, bad);
    nvec++; if (lat !== 4) begin nfail++; $display("FAIL rd_latency got %0d want 4", lat); end
    nvec++; if (rd !== 8'hA5 || er !== 1'b0) begin nfail++; $display("FAIL rd_data got %h/%b want a5/0", rd, er); end
    nvec++; if (nrd !== 1 || nwr !== 0 || ncen !== 3 || bad !== 1'b0) begin
      nfail++; $display("FAIL rd_pins got rd=%0d wr=%0d cen=%0d bad=%0d want 1/0/3/0", nrd, nwr, ncen, bad); end
  endtask

  task automatic test_back_to_back;
    int lat, nrd, nwr, nrst, ncen; logic [7:0] rd; logic er; bit bad;
    run_op(2'b01, 12'hC00, 8'h5A, lat, rd, er, nrd, nwr, nrst, ncen, bad);
    nvec++; if (req_ready !== 1'b0 || mem_cen !== 1'b1) begin
      nfail++; $display("FAIL resp_ready got ready=%b cen=%b want 0/1", req_ready, mem_cen); end
    @(negedge clk);
    nvec++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) begin
      nfail++; $display("FAIL idle_after_resp got ready=%b valid=%b rdata=%h want 1/0/00", req_ready, rsp_valid, rsp_rdata); end
    run_op(2'b00, 12'h000, 8'h00, lat, rd, er, nrd, nwr, nrst, ncen, bad);
    nvec++; if (lat !== 4 || rd !== 8'h00) begin nfail++; $display("FAIL bank0_read got lat=%0d data=%h want 4/00", lat, rd); end
    run_op(2'b00, 12'hC00, 8'h00, lat, rd, er, nrd, nwr, nrst, ncen, bad);
    nvec++; if (rd !== 8'h5A || bad !== 1'b0) begin nfail++; $display("FAIL bank3_read got %h bad=%0d want 5a/0", rd, bad); end
  endtask

  task automatic test_illegal;
    int lat, nrd, nwr, nrst, ncen; logic [7:0] rd; logic er; bit bad;
    run_op(2'b11, 12'h123, 8'h77, lat, rd, er, nrd, nwr, nrst, ncen, bad);
    nvec++; if (lat !== 1) begin nfail++; $display("FAIL ill_latency got %0d want 1", lat); end
    nvec++; if (nrd + nwr + nrst + ncen !== 0) begin
      nfail++; $display("FAIL ill_pins got rd=%0d wr=%0d rst=%0d cen=%0d want 0", nrd, nwr, nrst, ncen); end
    nvec++; if (er !== 1'b1 || rd !== 8'h00) begin nfail++; $display("FAIL ill_rsp got %h/%b want 00/1", rd, er); end
  endtask

  task automatic test_reset_midread;
    int lat, nrd, nwr, nrst, ncen; logic [7:0] rd; logic er; bit bad; bit seen;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_addr = 12'hC00;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    nvec++; if (mem_rd !== 1'b1) begin nfail++; $display("FAIL midrd_issue got rd=%b want 1", mem_rd); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    nvec++; if (mem_cen !== 1'b1 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_add !== 12'h000) begin
      nfail++; $display("FAIL midrd_reset got cen=%b ready=%b valid=%b add=%h want 1/1/0/000", mem_cen, req_ready, rsp_valid, mem_add); end
    rst = 1'b0;
    seen = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid) seen = 1; end
    nvec++; if (seen !== 1'b0) begin nfail++; $display("FAIL midrd_no_rsp got rsp_valid seen=%0d want 0", seen); end
    run_op(2'b00, 12'hC00, 8'h00, lat, rd, er, nrd, nwr, nrst, ncen, bad);
    nvec++; if (lat !== 4 || rd !== 8'h5A || er !== 1'b0) begin
      nfail++; $display("FAIL midrd_recover got lat=%0d data=%h err=%b want 4/5a/0", lat, rd, er); end
  endtask

  task automatic test_clear;
    int lat, nrd, nwr, nrst, ncen; logic [7:0] rd; logic er; bit bad;
    run_op(2'b10, 12'h000, 8'h00, lat, rd, er, nrd, nwr, nrst, ncen, bad);
    nvec++; if (lat !== 5) begin nfail++; $display("FAIL clr_latency got %0d want 5", lat); end
    nvec++; if (nrst !== 4 || ncen !== 4 || nrd !== 0 || nwr !== 0 || bad !== 1'b0) begin
      nfail++; $display("FAIL clr_pins got rst=%0d cen=%0d rd=%0d wr=%0d bad=%0d want 4/4/0/0/0", nrst, ncen, nrd, nwr, bad); end
    nvec++; if (rd !== 8'h00 || er !== 1'b0) begin nfail++; $display("FAIL clr_rsp got %h/%b want 00/0", rd, er); end
    run_op(2'b00, 12'h3FF, 8'h00, lat, rd, er, nrd, nwr, nrst, ncen, bad);
    nvec++; if (rd !== 8'h00 || lat !== 4) begin nfail++; $display("FAIL clr_read3ff got %h lat=%0d want 00/4", rd, lat); end
    run_op(2'b00, 12'hC00, 8'h00, lat, rd, er, nrd, nwr, nrst, ncen, bad);
    nvec++; if (rd !== 8'h00) begin nfail++; $display("FAIL clr_readc00 got %h want 00", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_illegal();
    test_reset_midread();
    test_clear();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

`default_nettype wire
